// File: rtl/mem_interface_unit.sv
// mem_interface_unit: responder for I-cache / D-cache line misses.
// Each request becomes a burst of LINE_WORDS single-word bus transfers.
// The I-cache has fixed priority over the D-cache.
// Optional build macro MEM_TIMEOUT_EN adds a memAck wait limit (TIMEOUT_CYCLES)
// that aborts the burst, pulses busErr and closes the owner's response.
module mem_interface_unit #(
    parameter int WORD_LENGTH    = 32,
    parameter int ADR_WIDTH      = 32,
    parameter int LINE_WORDS     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iReqValid,
    input  logic [ADR_WIDTH-1:0]   iReqAdr,
    output logic                   iReqReady,
    output logic                   iRspValid,
    output logic [WORD_LENGTH-1:0] iRspData,
    output logic                   iRspLast,
    input  logic                   dReqValid,
    input  logic                   dReqWrite,
    input  logic [ADR_WIDTH-1:0]   dReqAdr,
    output logic                   dReqReady,
    input  logic [WORD_LENGTH-1:0] dWrData,
    output logic                   dWrPop,
    output logic                   dRspValid,
    output logic [WORD_LENGTH-1:0] dRspData,
    output logic                   dRspLast,
    output logic                   memReq,
    output logic                   memWe,
    output logic [ADR_WIDTH-1:0]   memAdr,
    output logic [WORD_LENGTH-1:0] memWdata,
    input  logic                   memAck,
    input  logic [WORD_LENGTH-1:0] memRdata,
    output logic                   busErr
);

    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFF = BW + 2;
    localparam int TW  = ADR_WIDTH - OFF;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_READ  = 2'd1,
        D_READ  = 2'd2,
        D_WRITE = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [BW-1:0]          beat;
    logic [BW-1:0]          beat_inc;
    logic [TW-1:0]          tag;
    logic [TW-1:0]          acc_tag;
    logic                   mem_req_q;
    logic [ADR_WIDTH-1:0]   mem_adr_q;
    logic                   i_acc, d_acc, accept;
    logic                   beat_done, last_beat, burst_end, timeout;
    logic                   bus_err_q;
    logic                   i_rsp_valid, i_rsp_last, d_rsp_valid, d_rsp_last;
    logic [WORD_LENGTH-1:0] i_rsp_data, d_rsp_data;
    logic                   unused_adr_bits;

    // Offset bits below the line boundary are discarded by design.
    assign unused_adr_bits = ^{iReqAdr[OFF-1:0], dReqAdr[OFF-1:0]};

    assign i_acc     = (state == IDLE) && iReqValid;
    assign d_acc     = (state == IDLE) && dReqValid && !iReqValid;
    assign accept    = i_acc || d_acc;
    assign acc_tag   = iReqValid ? iReqAdr[ADR_WIDTH-1:OFF] : dReqAdr[ADR_WIDTH-1:OFF];
    // memAck only counts while a request is on the bus.
    assign beat_done = mem_req_q && memAck;
    assign last_beat = (beat == LAST_BEAT);
    assign beat_inc  = beat + BW'(1);
    assign burst_end = (beat_done && last_beat) || timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // Count stalled bus cycles; restart on every accept and every ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      wait_cnt <= '0;
        else if (accept || beat_done)  wait_cnt <= '0;
        else if (mem_req_q)            wait_cnt <= wait_cnt + CW'(1);
    end

    // Fires on the edge at which the counter would reach the limit.
    assign timeout = mem_req_q && !memAck && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: arbitrate in IDLE, return to IDLE when the burst ends.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_acc)      state_nxt = I_READ;
                else if (d_acc) state_nxt = dReqWrite ? D_WRITE : D_READ;
            end
            default: begin
                if (burst_end)  state_nxt = IDLE;
            end
        endcase
    end

    // Bus side: line tag, beat counter, registered request and address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag       <= '0;
            beat      <= '0;
            mem_req_q <= 1'b0;
            mem_adr_q <= '0;
        end else if (accept) begin
            tag       <= acc_tag;
            beat      <= '0;
            mem_req_q <= 1'b1;
            mem_adr_q <= {acc_tag, {OFF{1'b0}}};
        end else if (timeout) begin
            mem_req_q <= 1'b0;
        end else if (beat_done) begin
            beat <= beat_inc;
            if (last_beat) mem_req_q <= 1'b0;
            // Offset wraps inside the line; tag bits are never touched.
            else           mem_adr_q <= {tag, beat_inc, 2'b00};
        end
    end

    // Responses: one cycle after each ack, or after a timeout abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rsp_valid <= 1'b0;
            i_rsp_last  <= 1'b0;
            i_rsp_data  <= '0;
            d_rsp_valid <= 1'b0;
            d_rsp_last  <= 1'b0;
            d_rsp_data  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            i_rsp_valid <= (state == I_READ) && (beat_done || timeout);
            i_rsp_last  <= (state == I_READ) && burst_end;
            i_rsp_data  <= ((state == I_READ) && beat_done) ? memRdata : '0;
            // Writes report only once, on completion of the whole line.
            d_rsp_valid <= ((state == D_READ) && (beat_done || timeout)) ||
                           ((state == D_WRITE) && burst_end);
            d_rsp_last  <= ((state == D_READ) || (state == D_WRITE)) && burst_end;
            d_rsp_data  <= ((state == D_READ) && beat_done) ? memRdata : '0;
            bus_err_q   <= timeout;
        end
    end

    assign iReqReady = i_acc;
    assign dReqReady = d_acc;
    assign iRspValid = i_rsp_valid;
    assign iRspData  = i_rsp_data;
    assign iRspLast  = i_rsp_last;
    assign dRspValid = d_rsp_valid;
    assign dRspData  = d_rsp_data;
    assign dRspLast  = d_rsp_last;
    assign memReq    = mem_req_q;
    assign memWe     = (state == D_WRITE);
    assign memAdr    = mem_adr_q;
    assign memWdata  = dWrData;
    assign dWrPop    = (state == D_WRITE) && beat_done;
    assign busErr    = bus_err_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed bench for mem_interface_unit: per-cycle vector table for the
// I fill, priority and writeback bursts, plus hand sequences for reset,
// async abort and the memAck wait limit (MEM_TIMEOUT_EN builds).
module tb_mem_interface_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iReqValid = 1'b0;
    logic [31:0] iReqAdr = '0;
    logic        iReqReady;
    logic        iRspValid;
    logic [31:0] iRspData;
    logic        iRspLast;
    logic        dReqValid = 1'b0;
    logic        dReqWrite = 1'b0;
    logic [31:0] dReqAdr = '0;
    logic        dReqReady;
    logic [31:0] dWrData = '0;
    logic        dWrPop;
    logic        dRspValid;
    logic [31:0] dRspData;
    logic        dRspLast;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAdr;
    logic [31:0] memWdata;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = '0;
    logic        busErr;

    int checks = 0;
    int errors = 0;

    mem_interface_unit #(
        .WORD_LENGTH(32), .ADR_WIDTH(32), .LINE_WORDS(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .iReqValid(iReqValid), .iReqAdr(iReqAdr), .iReqReady(iReqReady),
        .iRspValid(iRspValid), .iRspData(iRspData), .iRspLast(iRspLast),
        .dReqValid(dReqValid), .dReqWrite(dReqWrite), .dReqAdr(dReqAdr),
        .dReqReady(dReqReady), .dWrData(dWrData), .dWrPop(dWrPop),
        .dRspValid(dRspValid), .dRspData(dRspData), .dRspLast(dRspLast),
        .memReq(memReq), .memWe(memWe), .memAdr(memAdr), .memWdata(memWdata),
        .memAck(memAck), .memRdata(memRdata), .busErr(busErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic        dw;
        logic [31:0] da;
        logic [31:0] wd;
        logic        ack;
        logic [31:0] rd;
        logic [1:0]  rdy;   // {iReqReady, dReqReady}
        logic [1:0]  mem;   // {memReq, memWe}
        logic [31:0] adr;
        logic        pop;
        logic [1:0]  irsp;  // {iRspValid, iRspLast}
        logic [31:0] idat;
        logic [1:0]  drsp;  // {dRspValid, dRspLast}
        logic [31:0] ddat;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic iv, logic [31:0] ia, logic dv, logic dw,
                                logic [31:0] da, logic [31:0] wd, logic ack,
                                logic [31:0] rd, logic [1:0] rdy, logic [1:0] mem,
                                logic [31:0] adr, logic pop, logic [1:0] irsp,
                                logic [31:0] idat, logic [1:0] drsp, logic [31:0] ddat);
        vec_t r;
        r.iv = iv;   r.ia = ia;    r.dv = dv;     r.dw = dw;
        r.da = da;   r.wd = wd;    r.ack = ack;   r.rd = rd;
        r.rdy = rdy; r.mem = mem;  r.adr = adr;   r.pop = pop;
        r.irsp = irsp; r.idat = idat; r.drsp = drsp; r.ddat = ddat;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iReqValid = 1'b0; iReqAdr = '0;
        dReqValid = 1'b0; dReqWrite = 1'b0; dReqAdr = '0; dWrData = '0;
        memAck = 1'b0; memRdata = '0;
    endtask

    // Runs until the watchdog ends the simulation; bounds any lost handshake.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // I fill 0x1234 with immediate ack, then a stray ack in IDLE
        vq.push_back(mk(1,32'h1234,0,0,0,0,0,0,        2'b10,2'b00,32'h0,0,    2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,0,1,32'hA0,          2'b00,2'b10,32'h1230,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,0,1,32'hA1,          2'b00,2'b10,32'h1234,0, 2'b10,32'hA0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,0,1,32'hA2,          2'b00,2'b10,32'h1238,0, 2'b10,32'hA1,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,0,1,32'hA3,          2'b00,2'b10,32'h123C,0, 2'b10,32'hA2,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,               2'b00,2'b00,32'h123C,0, 2'b11,32'hA3,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,0,1,32'hFF,          2'b00,2'b00,32'h123C,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,               2'b00,2'b00,32'h123C,0, 2'b00,0,2'b00,0));
        // Simultaneous I and D requests: I first, D fill accepted in the IDLE gap
        vq.push_back(mk(1,32'h0100,1,0,32'h2018,0,0,0, 2'b10,2'b00,32'h123C,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,1,0,32'h2018,0,1,32'hB0,   2'b00,2'b10,32'h0100,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,1,0,32'h2018,0,1,32'hB1,   2'b00,2'b10,32'h0104,0, 2'b10,32'hB0,2'b00,0));
        vq.push_back(mk(0,0,1,0,32'h2018,0,1,32'hB2,   2'b00,2'b10,32'h0108,0, 2'b10,32'hB1,2'b00,0));
        vq.push_back(mk(0,0,1,0,32'h2018,0,1,32'hB3,   2'b00,2'b10,32'h010C,0, 2'b10,32'hB2,2'b00,0));
        vq.push_back(mk(0,0,1,0,32'h2018,0,0,0,        2'b01,2'b00,32'h010C,0, 2'b11,32'hB3,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,0,1,32'hC0,          2'b00,2'b10,32'h2010,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,0,1,32'hC1,          2'b00,2'b10,32'h2014,0, 2'b00,0,2'b10,32'hC0));
        vq.push_back(mk(0,0,0,0,0,0,1,32'hC2,          2'b00,2'b10,32'h2018,0, 2'b00,0,2'b10,32'hC1));
        vq.push_back(mk(0,0,0,0,0,0,1,32'hC3,          2'b00,2'b10,32'h201C,0, 2'b00,0,2'b10,32'hC2));
        vq.push_back(mk(0,0,0,0,0,0,0,0,               2'b00,2'b00,32'h201C,0, 2'b00,0,2'b11,32'hC3));
        // D writeback to 0x2000, two wait states per beat
        vq.push_back(mk(0,0,1,1,32'h2000,32'h11,0,0,   2'b01,2'b00,32'h201C,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h11,0,0,          2'b00,2'b11,32'h2000,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h11,0,0,          2'b00,2'b11,32'h2000,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h11,1,32'hDEAD,   2'b00,2'b11,32'h2000,1, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h22,0,0,          2'b00,2'b11,32'h2004,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h22,0,0,          2'b00,2'b11,32'h2004,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h22,1,32'hDEAD,   2'b00,2'b11,32'h2004,1, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h33,0,0,          2'b00,2'b11,32'h2008,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h33,0,0,          2'b00,2'b11,32'h2008,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h33,1,32'hDEAD,   2'b00,2'b11,32'h2008,1, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h44,0,0,          2'b00,2'b11,32'h200C,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h44,0,0,          2'b00,2'b11,32'h200C,0, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,32'h44,1,32'hDEAD,   2'b00,2'b11,32'h200C,1, 2'b00,0,2'b00,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,               2'b00,2'b00,32'h200C,0, 2'b00,0,2'b11,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,               2'b00,2'b00,32'h200C,0, 2'b00,0,2'b00,0));

        // Reset state
        idle_inputs();
        #12;
        chk("reset iReqReady", {31'b0, iReqReady}, 0);
        chk("reset dReqReady", {31'b0, dReqReady}, 0);
        chk("reset rsp flags", {26'b0, iRspValid, iRspLast, dRspValid, dRspLast, dWrPop, busErr}, 0);
        chk("reset iRspData", iRspData, 0);
        chk("reset dRspData", dRspData, 0);
        chk("reset mem flags", {30'b0, memReq, memWe}, 0);
        chk("reset memAdr", memAdr, 0);
        chk("reset memWdata", memWdata, 0);
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            chk($sformatf("idle%0d memReq/readies", k), {29'b0, memReq, iReqReady, dReqReady}, 0);
        end

        // Vector table
        for (int i = 0; i < vq.size(); i++) begin
            iReqValid = vq[i].iv; iReqAdr = vq[i].ia;
            dReqValid = vq[i].dv; dReqWrite = vq[i].dw; dReqAdr = vq[i].da;
            dWrData = vq[i].wd; memAck = vq[i].ack; memRdata = vq[i].rd;
            #1;
            chk($sformatf("v%0d readies", i), {30'b0, iReqReady, dReqReady}, {30'b0, vq[i].rdy});
            chk($sformatf("v%0d memReq/memWe", i), {30'b0, memReq, memWe}, {30'b0, vq[i].mem});
            chk($sformatf("v%0d memAdr", i), memAdr, vq[i].adr);
            chk($sformatf("v%0d dWrPop", i), {31'b0, dWrPop}, {31'b0, vq[i].pop});
            chk($sformatf("v%0d iRsp", i), {30'b0, iRspValid, iRspLast}, {30'b0, vq[i].irsp});
            chk($sformatf("v%0d iRspData", i), iRspData, vq[i].idat);
            chk($sformatf("v%0d dRsp", i), {30'b0, dRspValid, dRspLast}, {30'b0, vq[i].drsp});
            chk($sformatf("v%0d dRspData", i), dRspData, vq[i].ddat);
            chk($sformatf("v%0d busErr", i), {31'b0, busErr}, 0);
            if (vq[i].mem[0]) chk($sformatf("v%0d memWdata", i), memWdata, vq[i].wd);
            next_cycle();
        end
        idle_inputs();

        // Async reset during beat 2 of an I fill
        iReqValid = 1'b1; iReqAdr = 32'h4004;
        #1 chk("abort accept", {31'b0, iReqReady}, 1);
        next_cycle();
        iReqValid = 1'b0; memAck = 1'b1; memRdata = 32'hD0;
        next_cycle();
        memRdata = 32'hD1;
        next_cycle();
        memAck = 1'b0;
        chk("abort beat2 memAdr", memAdr, 32'h4008);
        chk("abort beat2 memReq", {31'b0, memReq}, 1);
        #3 rst = 1'b0;
        #1;
        chk("abort memReq low", {31'b0, memReq}, 0);
        chk("abort rsp cleared", {30'b0, iRspValid, iRspLast}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("abort quiet%0d", k), {29'b0, memReq, iRspValid, iRspLast}, 0);
            next_cycle();
        end
        iReqValid = 1'b1; iReqAdr = 32'h5008;
        #1 chk("after abort accept", {31'b0, iReqReady}, 1);
        next_cycle();
        iReqValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            memAck = 1'b1; memRdata = 32'hE0 + k;
            #1 chk($sformatf("after abort memAdr%0d", k), memAdr, 32'h5000 + 4 * k);
            next_cycle();
        end
        memAck = 1'b0;
        chk("after abort last", {30'b0, iRspValid, iRspLast}, 2'b11);
        chk("after abort last data", iRspData, 32'hE3);
        chk("after abort memReq", {31'b0, memReq}, 0);
        next_cycle();

`ifdef MEM_TIMEOUT_EN
        // No ack ever: abort after TIMEOUT_CYCLES stalled cycles
        begin
            int n;
            bit seen;
            n = 0;
            seen = 1'b0;
            iReqValid = 1'b1; iReqAdr = 32'h7000;
            next_cycle();
            iReqValid = 1'b0;
            chk("timeout memReq rise", {31'b0, memReq}, 1);
            while (n < 40 && !seen) begin
                if (busErr) seen = 1'b1;
                else begin
                    n++;
                    next_cycle();
                end
            end
            chk("timeout seen", {31'b0, seen}, 1);
            chk("timeout delay", n, 8);
            chk("timeout memReq", {31'b0, memReq}, 0);
            chk("timeout iRsp", {30'b0, iRspValid, iRspLast}, 2'b11);
            chk("timeout iRspData", iRspData, 0);
            next_cycle();
            chk("timeout busErr pulse", {31'b0, busErr}, 0);
            chk("timeout idle", {30'b0, iRspValid, memReq}, 0);
        end
`else
        // Without the wait limit a stalled request holds indefinitely
        iReqValid = 1'b1; iReqAdr = 32'h6000;
        next_cycle();
        iReqValid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("stall%0d", k), {30'b0, memReq, busErr}, 2'b10);
            next_cycle();
        end
        for (int k = 0; k < 4; k++) begin
            memAck = 1'b1; memRdata = 32'hF0 + k;
            next_cycle();
        end
        memAck = 1'b0;
        chk("stall last", {30'b0, iRspValid, iRspLast}, 2'b11);
        chk("stall last data", iRspData, 32'hF3);
        chk("stall busErr", {31'b0, busErr}, 0);
        next_cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
